pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WORD_SIZE, default 9, instruction and offset width in trits.
REQ-002 Parameter MEM_ADDR_SIZE, default 3, PC width in trits.
REQ-003 Trit encoding SHALL be 2 bits per trit: 2'b11=-1, 2'b00=0, 2'b01=+1, 2'b10 invalid; trit 0 in bits [1:0].
REQ-004 clock  in  1  rising-edge clock; one clock domain.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  leave IDLE and begin fetching.
REQ-007 fetch_req  out  1  instruction fetch request to instruction memory.
REQ-008 fetch_addr  out  2*MEM_ADDR_SIZE  fetch address; always equals pc.
REQ-009 fetch_ack  in  1  memory returns instruction on fetch_data this cycle.
REQ-010 fetch_data  in  2*WORD_SIZE  fetched instruction word.
REQ-011 instr  out  2*WORD_SIZE  last captured instruction.
REQ-012 instr_valid  out  1  one-cycle pulse when instr is updated.
REQ-013 exec_done  in  1  execute stage finished the current instruction.
REQ-014 branch_valid  in  1  apply branch_offset instead of +1, sampled with exec_done.
REQ-015 branch_offset  in  2*WORD_SIZE  signed balanced-ternary relative offset.
REQ-016 halt_req  in  1  stop after the current instruction, sampled with exec_done.
REQ-017 pc  out  2*MEM_ADDR_SIZE  current program counter.
REQ-018 halted  out  1  high in HALT.
REQ-019 error  out  1  invalid-trit trap flag; only with the macro in REQ-036.

Function
REQ-020 States SHALL be IDLE, FETCH, EXEC and HALT; state encoding is free.
REQ-021 IDLE: outputs at reset values; start=1 -> FETCH next edge.
REQ-022 FETCH: fetch_req=1 combinationally, held until fetch_ack; no timeout.
REQ-023 FETCH with fetch_ack=1: instr<=fetch_data, instr_valid=1 next cycle only, -> EXEC; fetch_ack in the first FETCH cycle is legal (no wait states).
REQ-024 fetch_ack outside FETCH SHALL be ignored.
REQ-025 EXEC: fetch_req=0; wait for exec_done; no change while exec_done=0.
REQ-026 EXEC, exec_done=1, halt_req=1: -> HALT, pc unchanged; halt_req wins over branch_valid.
REQ-027 EXEC, exec_done=1, branch_valid=1: pc<=pc+trunc(branch_offset), -> FETCH.
REQ-028 EXEC, exec_done=1, otherwise: pc<=pc+1, -> FETCH.
REQ-029 trunc() SHALL keep the low MEM_ADDR_SIZE trits; higher trits are discarded.
REQ-030 Addition SHALL be trit-serial balanced-ternary with carry in {-1,0,+1}; final carry dropped, so the result is modulo 3^MEM_ADDR_SIZE (13+1=-13, -13-1=13).
REQ-031 HALT: halted=1, pc and instr held; exit only by reset.
REQ-032 start, exec_done, branch_valid and halt_req outside their sampling states SHALL have no effect.

Reset
REQ-033 reset_n=0 SHALL, asynchronously and mid-transaction, force IDLE, pc=0 (all 2'b00), instr=0, instr_valid=0, fetch_req=0, halted=0, error=0.
REQ-034 The first FETCH after reset_n deasserts SHALL need start=1 and SHALL use fetch_addr=0.

Configuration
REQ-035 Macro name SHALL be PC_INVALID_TRIT_TRAP_EN.
REQ-036 Defined: trit 2'b10 in the used low trits of branch_offset, when sampled under REQ-027 -> HALT, error=1 (sticky until reset), pc unchanged; undefined: error tied 0, 2'b10 treated as 0.

Verification
REQ-037 Reset, start, fetch_ack after 2 FETCH cycles with data 18'h00001 -> fetch_addr=0, instr=18'h00001, one instr_valid pulse.
REQ-038 exec_done without branch, repeated 3 times -> pc 0->1->2->3 ({00,01,00}).
REQ-039 pc=13 ({01,01,01}), exec_done -> pc=-13 ({11,11,11}); from pc=0 branch offset -1 -> pc=-1 ({00,00,11}).
REQ-040 Branch offset 27 (trit 3=+1, others 0) -> pc unchanged; offset 3 -> pc+3.
REQ-041 exec_done, branch_valid and halt_req high together -> HALT, halted=1, pc unchanged, no further fetch_req; reset_n low during FETCH -> pc=0, fetch_req=0 immediately.
REQ-042 With PC_INVALID_TRIT_TRAP_EN, offset trit 0 = 2'b10 -> error=1, HALT; without the macro the same stimulus -> pc+0, back to FETCH.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction fetch/execute sequencer with a balanced-ternary
// program counter (2 bits per trit: 11=-1, 00=0, 01=+1, 10=invalid).
//
// Optional build macro PC_INVALID_TRIT_TRAP_EN: when defined, an invalid trit
// in the used low trits of a taken branch offset traps to HALT and raises a
// sticky error flag. When undefined, error is tied low and the invalid code
// is read as 0.
//
// Handshake: fetch_req is high for every cycle the sequencer is in FETCH and
// stays high until the memory answers with fetch_ack. The word on fetch_data
// is captured on the edge where fetch_ack is seen, and instr_valid pulses for
// exactly the following cycle. exec_done (with branch_valid, branch_offset and
// halt_req) is sampled only in EXEC. Each input is ignored in every other state.
module pc_sequencer #(
  parameter int WORD_SIZE     = 9,
  parameter int MEM_ADDR_SIZE = 3
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  output logic                       fetch_req,
  output logic [2*MEM_ADDR_SIZE-1:0] fetch_addr,
  input  logic                       fetch_ack,
  input  logic [2*WORD_SIZE-1:0]     fetch_data,
  output logic [2*WORD_SIZE-1:0]     instr,
  output logic                       instr_valid,
  input  logic                       exec_done,
  input  logic                       branch_valid,
  input  logic [2*WORD_SIZE-1:0]     branch_offset,
  input  logic                       halt_req,
  output logic [2*MEM_ADDR_SIZE-1:0] pc,
  output logic                       halted,
  output logic                       error,
  output logic [1:0]                 debug_state
);

  localparam int AW = 2 * MEM_ADDR_SIZE;
  localparam int WW = 2 * WORD_SIZE;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          state;
  logic [AW-1:0]   pc_q;
  logic [WW-1:0]   instr_q;
  logic            instr_valid_q;
  logic [AW-1:0]   pc_inc;
  logic [AW-1:0]   pc_branch;
  logic [AW-1:0]   offset_low;

  // Trit value of a 2-bit code; the invalid code reads as 0.
  function automatic int trit_val(input logic [1:0] t);
    case (t)
      2'b01:   return 1;
      2'b11:   return -1;
      default: return 0;
    endcase
  endfunction

  // 2-bit code of a trit value in {-1,0,+1}.
  function automatic logic [1:0] trit_enc(input int v);
    if (v == 1)       return 2'b01;
    else if (v == -1) return 2'b11;
    else              return 2'b00;
  endfunction

  // Keep only the trits that fit the program counter.
  function automatic logic [AW-1:0] trunc_offset(input logic [WW-1:0] off);
    return off[AW-1:0];
  endfunction

  // Trit-serial balanced-ternary add; the final carry is dropped so the
  // result wraps modulo 3^MEM_ADDR_SIZE.
  function automatic logic [AW-1:0] tern_add(input logic [AW-1:0] a,
                                             input logic [AW-1:0] b);
    int carry;
    int s;
    logic [AW-1:0] r;
    carry = 0;
    r     = '0;
    for (int i = 0; i < MEM_ADDR_SIZE; i++) begin
      s = trit_val(a[2*i +: 2]) + trit_val(b[2*i +: 2]) + carry;
      if (s > 1) begin
        s     = s - 3;
        carry = 1;
      end else if (s < -1) begin
        s     = s + 3;
        carry = -1;
      end else begin
        carry = 0;
      end
      r[2*i +: 2] = trit_enc(s);
    end
    return r;
  endfunction

  // Next-pc candidates for sequential flow and for a taken branch.
  always_comb begin
    offset_low = trunc_offset(branch_offset);
    pc_inc     = tern_add(pc_q, {{(AW-2){1'b0}}, 2'b01});
    pc_branch  = tern_add(pc_q, offset_low);
  end

`ifdef PC_INVALID_TRIT_TRAP_EN
  logic offset_bad;
  logic error_q;

  // Flag any invalid trit code among the offset trits that reach the pc.
  always_comb begin
    offset_bad = 1'b0;
    for (int i = 0; i < MEM_ADDR_SIZE; i++) begin
      if (offset_low[2*i +: 2] == 2'b10) offset_bad = 1'b1;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // Sequencer FSM with the pc, captured instruction and valid pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      pc_q          <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
`ifdef PC_INVALID_TRIT_TRAP_EN
      error_q       <= 1'b0;
`endif
    end else begin
      instr_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          if (fetch_ack) begin
            instr_q       <= fetch_data;
            instr_valid_q <= 1'b1;
            state         <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (exec_done) begin
            if (halt_req) begin
              state <= S_HALT;
            end else if (branch_valid) begin
`ifdef PC_INVALID_TRIT_TRAP_EN
              if (offset_bad) begin
                error_q <= 1'b1;
                state   <= S_HALT;
              end else begin
                pc_q  <= pc_branch;
                state <= S_FETCH;
              end
`else
              pc_q  <= pc_branch;
              state <= S_FETCH;
`endif
            end else begin
              pc_q  <= pc_inc;
              state <= S_FETCH;
            end
          end
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

  assign fetch_req   = (state == S_FETCH);
  assign fetch_addr  = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign halted      = (state == S_HALT);
  assign debug_state = state;

endmodule
